// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the EX (port 0) and MEM (port 1) write-back paths.
// Optional macro WB_ZERO_FILTER_EN: requests to register 0 are absorbed without issuing a write.
module regfile_wb_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              conflict,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic rr_last;
    logic zero0;
    logic zero1;
    logic arb0;
    logic arb1;
    logic grant0;
    logic grant1;
    logic xfer;
    logic stall;

    // Split each request into "absorbed register-0 request" and "needs the write port"
    always_comb begin
        zero0 = 1'b0;
        zero1 = 1'b0;
`ifdef WB_ZERO_FILTER_EN
        zero0 = req0_valid && (req0_addr == '0);
        zero1 = req1_valid && (req1_addr == '0);
`endif
        arb0 = req0_valid && !zero0;
        arb1 = req1_valid && !zero1;
    end

    // Round-robin grant: on a tie the port that did not win last time goes first
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (arb0 && arb1) begin
                grant0 = rr_last;
                grant1 = !rr_last;
            end else begin
                grant0 = arb0;
                grant1 = arb1;
            end
        end
    end

    always_comb begin
        req0_ready = !rst && (grant0 || zero0);
        req1_ready = !rst && (grant1 || zero1);
        xfer       = grant0 || grant1;
        conflict   = arb0 && arb1;
        stall      = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last   <= 1'b1;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            stall_cnt <= '0;
        end else begin
            wr_en <= xfer;
            if (xfer) begin
                rr_last <= grant1;
                wr_addr <= grant1 ? req1_addr : req0_addr;
                wr_data <= grant1 ? req1_data : req0_data;
            end
            // Saturate instead of wrapping so a long stall never reads as a short one
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; honours WB_ZERO_FILTER_EN when defined.
module tb_regfile_wb_arbiter;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              conflict;
    logic [CNT_W-1:0]  stall_cnt;

    int total;
    int bad;

    regfile_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .conflict   (conflict),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 32'h1;
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h2;
        #1;
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%b exp=0", req0_ready); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready1 got=%b exp=0", req1_ready); end
        @(posedge clk); #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
        total++; if (wr_addr !== 5'd0) begin bad++; $display("FAIL rst_wr_addr got=%h exp=0", wr_addr); end
        total++; if (wr_data !== 32'd0) begin bad++; $display("FAIL rst_wr_data got=%h exp=0", wr_data); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall got=%h exp=0", stall_cnt); end
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hDEADBEEF;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%b exp=1", req0_ready); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL single_ready1 got=%b exp=0", req1_ready); end
        total++; if (conflict !== 1'b0) begin bad++; $display("FAIL single_conflict got=%b exp=0", conflict); end
        @(posedge clk); #1;
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL single_wr_en got=%b exp=1", wr_en); end
        total++; if (wr_addr !== 5'd3) begin bad++; $display("FAIL single_wr_addr got=%h exp=3", wr_addr); end
        total++; if (wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wr_data got=%h exp=deadbeef", wr_data); end
        @(negedge clk);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL single_wr_en_off got=%b exp=0", wr_en); end
        total++; if (wr_addr !== 5'd3) begin bad++; $display("FAIL single_addr_hold got=%h exp=3", wr_addr); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL single_stall got=%h exp=0", stall_cnt); end
    endtask

    task automatic test_first_tie();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h22;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL tie_ready0 got=%b exp=1", req0_ready); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL tie_ready1 got=%b exp=0", req1_ready); end
        total++; if (conflict !== 1'b1) begin bad++; $display("FAIL tie_conflict got=%b exp=1", conflict); end
        @(posedge clk); #1;
        total++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'h11}) begin bad++; $display("FAIL tie_wr0 got=%b/%h/%h exp=1/05/11", wr_en, wr_addr, wr_data); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL tie_stall got=%h exp=1", stall_cnt); end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL tie_ready1_next got=%b exp=1", req1_ready); end
        @(posedge clk); #1;
        total++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd6, 32'h22}) begin bad++; $display("FAIL tie_wr1 got=%b/%h/%h exp=1/06/22", wr_en, wr_addr, wr_data); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL tie_stall2 got=%h exp=1", stall_cnt); end
        @(negedge clk);
        req1_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic exp_g;
        do_reset();
        d0 = 32'hA000;
        d1 = 32'hB000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req0_valid = 1'b1; req0_addr = 5'd1; req0_data = d0;
            req1_valid = 1'b1; req1_addr = 5'd2; req1_data = d1;
            exp_g = (i % 2) == 1;
            #1;
            total++; if ({req1_ready, req0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin bad++; $display("FAIL b2b_grant%0d got=%b%b exp_port=%0d", i, req1_ready, req0_ready, exp_g); end
            @(posedge clk); #1;
            total++; if ({wr_en, wr_addr, wr_data} !== (exp_g ? {1'b1, 5'd2, d1} : {1'b1, 5'd1, d0})) begin bad++; $display("FAIL b2b_wr%0d got=%b/%h/%h", i, wr_en, wr_addr, wr_data); end
            if (exp_g) d1 = d1 + 32'h1; else d0 = d0 + 32'h1;
        end
        total++; if (stall_cnt !== 16'd6) begin bad++; $display("FAIL b2b_stall got=%h exp=6", stall_cnt); end
    endtask

    // Continues from test_back_to_back: one more tie flips rr_last to 0 before reset
    task automatic test_reset_mid();
        @(negedge clk);
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL mid_pre_ready0 got=%b exp=1", req0_ready); end
        @(posedge clk); #1;
        total++; if (stall_cnt !== 16'd7) begin bad++; $display("FAIL mid_pre_stall got=%h exp=7", stall_cnt); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL mid_ready got=%b%b exp=00", req0_ready, req1_ready); end
        @(posedge clk); #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mid_wr_en got=%b exp=0", wr_en); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL mid_stall got=%h exp=0", stall_cnt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if ({req1_ready, req0_ready} !== 2'b01) begin bad++; $display("FAIL mid_rr_reset got=%b%b exp=01", req1_ready, req0_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h4;
        req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h8;
        repeat (65534) @(posedge clk);
        #1;
        total++; if (stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", stall_cnt); end
        repeat (5) @(posedge clk);
        #1;
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_zero_reg();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hAA;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hBB;
        #1;
`ifdef WB_ZERO_FILTER_EN
        total++; if ({req0_ready, req1_ready} !== 2'b11) begin bad++; $display("FAIL zero_ready got=%b%b exp=11", req0_ready, req1_ready); end
        total++; if (conflict !== 1'b0) begin bad++; $display("FAIL zero_conflict got=%b exp=0", conflict); end
        @(posedge clk); #1;
        total++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd7, 32'hBB}) begin bad++; $display("FAIL zero_wr got=%b/%h/%h exp=1/07/bb", wr_en, wr_addr, wr_data); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL zero_stall got=%h exp=0", stall_cnt); end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL zero_wr_off got=%b exp=0", wr_en); end
`else
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL zero_ready got=%b%b exp=10", req0_ready, req1_ready); end
        total++; if (conflict !== 1'b1) begin bad++; $display("FAIL zero_conflict got=%b exp=1", conflict); end
        @(posedge clk); #1;
        total++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd0, 32'hAA}) begin bad++; $display("FAIL zero_wr0 got=%b/%h/%h exp=1/00/aa", wr_en, wr_addr, wr_data); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL zero_stall got=%h exp=1", stall_cnt); end
        @(negedge clk);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        total++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd7, 32'hBB}) begin bad++; $display("FAIL zero_wr1 got=%b/%h/%h exp=1/07/bb", wr_en, wr_addr, wr_data); end
        @(negedge clk);
        req1_valid = 1'b0;
`endif
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        test_reset();
        test_single();
        test_first_tie();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        test_zero_reg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
